// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: counter-chain digits and controls in,
// multiplexed common-anode select/segment lines out.
interface seg_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                    En;
    logic [4*N_DIGITS-1:0]   bcd_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    blank_lz;
    logic [N_DIGITS-1:0]     sel;
    logic [7:0]              seg;

    modport master (output En, bcd_in, dp_in, blank_lz, input sel, seg);
    modport slave  (input En, bcd_in, dp_in, blank_lz, output sel, seg);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver: snapshots all digits once per frame,
// then scans them at SCAN_DIV clocks per digit with leading-zero blanking and dp.
module seg_scan_driver #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input logic               Clk,
    input logic               Rst_n,
    seg_scan_driver_if.slave  bus
);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    typedef enum logic {ST_LOAD, ST_SCAN} state_t;

    state_t                state, state_next;
    logic                  load_en, scan_en;
    logic [CNT_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] snap_bcd;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   sel_q, sel_next;
    logic [7:0]            seg_q, seg_next;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  lz_chain;
    logic [3:0]            digit_cur;
    logic                  tick, last_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // ST_LOAD is the load_pending cycle: one fresh snapshot before any digit is lit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_LOAD;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_next = state;
        if (!bus.En)               state_next = ST_LOAD;
        else if (state == ST_LOAD) state_next = ST_SCAN;
    end

    always_comb begin
        load_en = bus.En && (state == ST_LOAD);
        scan_en = bus.En && (state == ST_SCAN);
    end

    // A digit above 0 is a leading zero when it and every higher digit are 0.
    always_comb begin
        lz_chain = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            lz_chain   = lz_chain && (snap_bcd[4*i +: 4] == 4'd0);
            lz_mask[i] = lz_chain;
        end
    end

    always_comb begin
        digit_cur  = snap_bcd[{idx, 2'b00} +: 4];
        tick       = (div_cnt == CNT_W'(SCAN_DIV - 1));
        last_digit = (idx == IDX_W'(N_DIGITS - 1));
        sel_next   = ~(N_DIGITS'(1) << idx);
        seg_next   = {~snap_dp[idx],
                      (bus.blank_lz && lz_mask[idx]) ? 7'h7F : decode(digit_cur)};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!Rst_n) begin
            div_cnt  <= '0;
            idx      <= '0;
            snap_bcd <= '0;
            snap_dp  <= '0;
            sel_q    <= '1;
            seg_q    <= 8'hFF;
        end else if (!bus.En) begin
            div_cnt <= '0;
            idx     <= '0;
            sel_q   <= '1;
            seg_q   <= 8'hFF;
        end else if (load_en) begin
            snap_bcd <= bus.bcd_in;
            snap_dp  <= bus.dp_in;
        end else if (scan_en) begin
            sel_q <= sel_next;
            seg_q <= seg_next;
            if (tick) begin
                div_cnt <= '0;
                if (last_digit) begin
                    idx      <= '0;
                    snap_bcd <= bus.bcd_in;
                    snap_dp  <= bus.dp_in;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign bus.sel = sel_q;
    assign bus.seg = seg_q;
endmodule
